// File: rtl/prog_seq_ctrl.sv
// Program sequencer: owns the PC, fetches 17-bit words from a synchronous
// instruction memory, resolves nop/branches/endop and issues the rest.
//
// state  | meaning
// IDLE   | waiting for start, pc retained
// FETCH  | pc presented to instruction memory
// LOAD   | memory word captured into ir, pc advanced
// DECODE | branch resolution on z_flag, or dispatch
// ISSUE  | instruction offered to datapath until stall is low
// DONE   | one-cycle done pulse after endop
module prog_seq_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int OPC_W   = 5,
  parameter int INSTR_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               z_flag,
  input  logic               stall,
  output logic               instr_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  operand,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [OPC_W-1:0] OPC_JPNZ  = OPC_W'(24);
  localparam logic [OPC_W-1:0] OPC_JMPZ  = OPC_W'(26);
  localparam logic [OPC_W-1:0] OPC_NOP   = OPC_W'(28);
  localparam logic [OPC_W-1:0] OPC_ENDOP = OPC_W'(31);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [OPC_W-1:0]   ir_opc;
  logic [ADDR_W-1:0]  ir_opr;

  assign ir_opc = ir[INSTR_W-1 -: OPC_W];
  assign ir_opr = ir[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = start_pc;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        ir_nxt    = instr_in;
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Branches redirect the very next fetch; no delay slot.
        unique case (ir_opc)
          OPC_JPNZ: begin
            if (!z_flag) pc_nxt = ir_opr;
            state_nxt = S_FETCH;
          end
          OPC_JMPZ: begin
            if (z_flag) pc_nxt = ir_opr;
            state_nxt = S_FETCH;
          end
          OPC_NOP:   state_nxt = S_FETCH;
          OPC_ENDOP: state_nxt = S_DONE;
          default:   state_nxt = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (!stall) state_nxt = S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // All outputs decode straight from registers, so none depend on inputs.
  assign instr_addr  = pc;
  assign opcode      = ir_opc;
  assign operand     = ir_opr;
  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: instruction-level reference model compared every
// cycle, plus directed programs with hand-computed timing expectations.
module tb_prog_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_pc = '0;
  logic [11:0] instr_addr;
  logic [16:0] instr_in = '0;
  logic        z_flag = 1'b0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [4:0]  opcode;
  logic [11:0] operand;
  logic        busy;
  logic        done;

  prog_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .instr_addr(instr_addr), .instr_in(instr_in), .z_flag(z_flag),
    .stall(stall), .instr_valid(instr_valid), .opcode(opcode),
    .operand(operand), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [16:0] mem [4096];
  always @(posedge clk) instr_in <= mem[instr_addr];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int vq_cyc[$];
  int vq_opc[$];
  int vq_opr[$];
  int dq_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks the instruction being executed (address m_a)
  // and how many cycles into it we are (m_k); cost rules come straight
  // from the per-instruction cycle counts.
  bit          m_busy = 1'b0;
  logic [11:0] m_a = '0;
  logic [11:0] m_idle_addr = '0;
  int          m_k = 0;
  logic [16:0] m_w = '0;

  function automatic bit is_dp(input logic [4:0] o);
    return !(o == 5'd28 || o == 5'd24 || o == 5'd26 || o == 5'd31);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy = 1'b0;
      m_idle_addr = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_a = start_pc;
        m_k = 0;
      end
    end else begin
      case (m_k)
        0: m_k = 1;
        1: begin m_w = mem[m_a]; m_k = 2; end
        2: begin
          case (m_w[16:12])
            5'd28: begin m_a = m_a + 12'd1; m_k = 0; end
            5'd24: begin m_a = z_flag ? m_a + 12'd1 : m_w[11:0]; m_k = 0; end
            5'd26: begin m_a = z_flag ? m_w[11:0] : m_a + 12'd1; m_k = 0; end
            default: m_k = 3;
          endcase
        end
        default: begin
          if (m_w[16:12] == 5'd31) begin
            m_busy = 1'b0;
            m_idle_addr = m_a + 12'd1;
          end else if (!stall) begin
            m_a = m_a + 12'd1;
            m_k = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [11:0] e_addr;
    bit e_valid, e_done;
    e_addr  = !m_busy ? m_idle_addr : (m_k < 2 ? m_a : m_a + 12'd1);
    e_valid = m_busy && m_k == 3 && is_dp(m_w[16:12]);
    e_done  = m_busy && m_k == 3 && m_w[16:12] == 5'd31;
    if (chk_en) begin
      chk("instr_addr", 32'(instr_addr), 32'(e_addr));
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(e_done));
      if (e_valid) begin
        chk("opcode", 32'(opcode), 32'(m_w[16:12]));
        chk("operand", 32'(operand), 32'(m_w[11:0]));
      end
    end
    if (instr_valid) begin
      vq_cyc.push_back(cyc);
      vq_opc.push_back(int'(opcode));
      vq_opr.push_back(int'(operand));
    end
    if (done) dq_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    vq_cyc.delete(); vq_opc.delete(); vq_opr.delete(); dq_cyc.delete();
  endtask

  task automatic run_start(input logic [11:0] pc);
    start_pc = pc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick(1);
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 17'h1F000;
    mem[0]  = 17'h03000;
    mem[1]  = 17'h13000;
    mem[2]  = 17'h1F000;
    mem[30] = 17'h18028;
    mem[50] = 17'h13ABC;
    mem[5]  = 17'h0A005;
    mem[4095] = 17'h1C000;

    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick(2);

    // ldac, add, endop from address 0
    clear_log();
    run_start(12'd0);
    chk("t1_fetch_addr", 32'(instr_addr), 32'd0);
    chk("t1_fetch_busy", 32'(busy), 32'd1);
    wait_idle(40);
    chk("t1_vcount", vq_cyc.size(), 2);
    chk("t1_dcount", dq_cyc.size(), 1);
    if (vq_cyc.size() == 2 && dq_cyc.size() == 1) begin
      chk("t1_opc0", vq_opc[0], 3);
      chk("t1_opc1", vq_opc[1], 19);
      chk("t1_vgap", vq_cyc[1] - vq_cyc[0], 4);
      chk("t1_done_lat", dq_cyc[0] - vq_cyc[1], 4);
    end

    // jpnz / jmpz at 30 targeting 40
    for (int t = 0; t < 4; t++) begin
      mem[30] = (t < 2) ? 17'h18028 : 17'h1A028;
      z_flag = t[0];
      run_start(12'd30);
      tick(3);
      chk("branch_addr", 32'(instr_addr),
          (t == 0 || t == 3) ? 32'd40 : 32'd31);
      wait_idle(20);
    end
    z_flag = 1'b0;

    // add with three stall cycles
    clear_log();
    stall = 1'b1;
    run_start(12'd50);
    tick(6);
    stall = 1'b0;
    tick(1);
    chk("stall_next_fetch", 32'(instr_addr), 32'd51);
    chk("stall_vcount", vq_cyc.size(), 4);
    if (vq_cyc.size() == 4) begin
      chk("stall_opc_last", vq_opc[3], 19);
      chk("stall_opr_last", vq_opr[3], 32'hABC);
    end
    wait_idle(20);

    // nop at 4095 wraps pc to 0, then runs the first program
    clear_log();
    run_start(12'd4095);
    tick(2);
    chk("wrap_decode_addr", 32'(instr_addr), 32'd0);
    tick(1);
    chk("wrap_fetch_addr", 32'(instr_addr), 32'd0);
    chk("wrap_nop_novalid", vq_cyc.size(), 0);
    wait_idle(40);

    // reset mid-issue while stalled
    stall = 1'b1;
    run_start(12'd50);
    tick(4);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(instr_addr), 32'd0);
    chk("mid_rst_opcode", 32'(opcode), 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    tick(1);
    clear_log();
    run_start(12'd5);
    chk("restart_addr", 32'(instr_addr), 32'd5);
    wait_idle(20);
    chk("restart_vcount", vq_cyc.size(), 1);
    if (vq_cyc.size() == 1) chk("restart_opc", vq_opc[0], 10);

    // start held high while busy and through DONE
    clear_log();
    start_pc = 12'd0;
    start = 1'b1;
    tick(1);
    start_pc = 12'd30;
    tick(12);
    start = 1'b0;
    tick(6);
    chk("spam_dcount", dq_cyc.size(), 1);
    chk("spam_vcount", vq_cyc.size(), 2);
    chk("spam_busy", 32'(busy), 32'd0);
    chk("spam_addr", 32'(instr_addr), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
